regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Write-back scheduler for the 16-entry register file (r0..r15, TAM bits each).
- Arbitrates NREQ write-back requesters (ALU, load unit, I/O) onto the single register-file write port, round-robin.
- Holds a 16-bit busy scoreboard of pending destination registers and raises a stall to issue on RAW/WAW hazards.
- Sits between the execute/memory units and the register-file input demux; drives its write enable, address and data.

Parameters:
- TAM, 16, register data width.
- NREQ, 3, number of write-back requesters (2..4).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- req_valid  input  NREQ  requester i holds a write.
- req_addr  input  4*NREQ  destination register of requester i, slice [4i+3:4i].
- req_data  input  TAM*NREQ  write data of requester i, slice [TAM*i+TAM-1:TAM*i].
- req_ready  output  NREQ  one-hot grant, combinational.
- wr_en  output  1  register-file write strobe, registered.
- wr_addr  output  4  register-file write address, registered.
- wr_data  output  TAM  register-file write data, registered.
- rsv_en  input  1  issue reserves a destination register.
- rsv_addr  input  4  register being reserved.
- rs_a_en, rs_b_en  input  1 each  source operand used.
- rs_a, rs_b  input  4 each  source register addresses.
- stall  output  1  hazard, combinational.
- busy  output  16  scoreboard state, registered.
- wb_err  output  1  sticky: write to a non-busy register.

Behaviour:
- Reset (rst=0, asynchronous) clears all state: busy=0, rr_ptr=0, wr_en=0, wr_addr=0, wr_data=0, wb_err=0. req_ready is 0 while rst=0.
- Reset asserted mid-operation discards any pending write and all reservations.
- Arbitration:
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ. The first valid index g gets req_ready[g]=1; all other ready bits are 0.
  - Accept occurs when req_valid[g] & req_ready[g]. At most one accept per cycle.
  - On accept: rr_ptr <= (g+1) mod NREQ. With no accept, rr_ptr holds.
  - A requester keeps valid, addr and data stable until accepted.
- Write port latency is 1 cycle. On the edge after accept: wr_en=1, wr_addr=req_addr[g], wr_data=req_data[g]. With no accept, wr_en=0 and wr_addr/wr_data hold their last values.
- Scoreboard update at each edge, in order:
  - Clear busy[req_addr[g]] on accept.
  - Set busy[rsv_addr] if rsv_en & ~stall.
  - Set and clear on the same address in the same cycle: set wins, busy stays 1.
- wb_err is set when an accept targets a register with busy=0. It stays set until reset. The write is still performed.
- stall = (rs_a_en & busy[rs_a]) | (rs_b_en & busy[rs_b]) | (rsv_en & busy[rsv_addr]).
  - busy here is the registered value.
  - A write accepted this cycle does not clear stall until the next cycle.
- Issue must not consume rsv_en while stall=1. The scheduler ignores rsv_en when stall=1.
- A requester with valid held and all others idle is granted every cycle (back-to-back, 1 write/cycle).
- With all NREQ requesters continuously valid, grants rotate 0,1,..,NREQ-1,0,... No requester waits more than NREQ-1 cycles.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs byp_a_hit, byp_b_hit (1 each) and byp_a_data, byp_b_data (TAM each).
  - byp_x_hit=1 when an accept occurs this cycle with req_addr[g]==rs_x and rs_x_en=1; then byp_x_data=req_data[g], else 0.
  - A hitting operand does not contribute to stall. The WAW term is unchanged.
- Undefined: these ports are absent and stall follows the base equation exactly.

Test Plan:
- Reset and basic write:
  - Stimulus: rst=0 then 1; rsv_en with rsv_addr=5; next cycle req_valid=001, addr0=5, data0=16'hA5A5.
  - Response: busy=16'h0020 after the reservation; req_ready=001; next cycle wr_en=1, wr_addr=5, wr_data=A5A5, busy=0, wb_err=0.
- Round-robin fairness:
  - Stimulus: r1, r2, r3 reserved; req_valid=111 held with addr0/1/2 = 1/2/3 (each requester holds until accepted).
  - Response: grants 001, 010, 100 on consecutive cycles; wr_addr sequence 1, 2, 3.
- RAW stall:
  - Stimulus: busy[7]=1, rs_a_en=1, rs_a=7.
  - Response: stall=1 until the cycle after the r7 accept, then stall=0. With WB_BYPASS_EN: stall=0 in the accept cycle, byp_a_hit=1, byp_a_data=write data.
- WAW and simultaneous set/clear:
  - Stimulus 1: busy[3]=1, rsv_en with rsv_addr=3. Response: stall=1, busy unchanged.
  - Stimulus 2: busy=0, rsv_en with rsv_addr=4 in the same cycle as an accepted write to r4. Response: busy[4]=1 afterwards.
- Unreserved write:
  - Stimulus: busy=0, write to r9 with data 16'h0001.
  - Response: wr_en=1, wr_addr=9 next cycle; wb_err=1 and stays 1.
- Async reset mid-burst:
  - Stimulus: drop rst between clock edges while req_valid=111 and busy=16'h000E.
  - Response: busy=0, wr_en=0, req_ready=0 immediately, without waiting for a clock edge; rr_ptr=0 after release.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: round-robin write-back arbiter and busy scoreboard for a 16 x TAM register file
// Define WB_BYPASS_EN to forward the accepted write to the source operands in the same cycle.
module regfile_wb_scheduler #(
    parameter int TAM  = 16,
    parameter int NREQ = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_addr,
    input  logic [TAM*NREQ-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                wr_en,
    output logic [3:0]          wr_addr,
    output logic [TAM-1:0]      wr_data,
    input  logic                rsv_en,
    input  logic [3:0]          rsv_addr,
    input  logic                rs_a_en,
    input  logic                rs_b_en,
    input  logic [3:0]          rs_a,
    input  logic [3:0]          rs_b,
    output logic                stall,
    output logic [15:0]         busy,
    output logic                wb_err
`ifdef WB_BYPASS_EN
    ,
    output logic                byp_a_hit,
    output logic                byp_b_hit,
    output logic [TAM-1:0]      byp_a_data,
    output logic [TAM-1:0]      byp_b_data
`endif
);
    localparam logic [1:0] LAST = 2'(NREQ - 1);
    localparam logic [2:0] NR   = 3'(NREQ);

    logic [1:0]     rr_ptr, g, nxt_ptr;
    logic [2:0]     j;
    logic           found, accept, hit_a, hit_b;
    logic [3:0]     g_addr;
    logic [TAM-1:0] g_data;
    logic [15:0]    busy_nxt;

    // first valid requester at or after rr_ptr, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        g = '0;
        j = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, rr_ptr} + 3'(k);
            j = (j >= NR) ? j - NR : j;
            if (!found && req_valid[j[1:0]]) begin
                found = 1'b1;
                g = j[1:0];
            end
        end
    end

    assign accept    = found & rst;
    assign req_ready = accept ? NREQ'(1) << g : '0;
    assign nxt_ptr   = (g == LAST) ? 2'd0 : g + 2'd1;
    assign g_addr    = req_addr[4*g +: 4];
    assign g_data    = req_data[TAM*g +: TAM];

`ifdef WB_BYPASS_EN
    assign hit_a      = accept & rs_a_en & (g_addr == rs_a);
    assign hit_b      = accept & rs_b_en & (g_addr == rs_b);
    assign byp_a_hit  = hit_a;
    assign byp_b_hit  = hit_b;
    assign byp_a_data = hit_a ? g_data : '0;
    assign byp_b_data = hit_b ? g_data : '0;
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif

    assign stall = (rs_a_en & busy[rs_a] & ~hit_a) | (rs_b_en & busy[rs_b] & ~hit_b)
                 | (rsv_en & busy[rsv_addr]);

    // the reservation is applied after the clear so set wins on the same register
    always_comb begin
        busy_nxt = busy;
        if (accept) busy_nxt[g_addr] = 1'b0;
        if (rsv_en && !stall) busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            busy    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wb_err  <= 1'b0;
        end else begin
            wr_en <= accept;
            busy  <= busy_nxt;
            if (accept) begin
                rr_ptr  <= nxt_ptr;
                wr_addr <= g_addr;
                wr_data <= g_data;
                if (!busy[g_addr]) wb_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed bench with a write-back scoreboard for regfile_wb_scheduler
module tb_regfile_wb_scheduler;
    localparam int TAM = 16;
    localparam int NREQ = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [4*NREQ-1:0]   req_addr;
    logic [TAM*NREQ-1:0] req_data;
    logic [NREQ-1:0]     req_ready;
    logic                wr_en;
    logic [3:0]          wr_addr;
    logic [TAM-1:0]      wr_data;
    logic                rsv_en;
    logic [3:0]          rsv_addr;
    logic                rs_a_en, rs_b_en;
    logic [3:0]          rs_a, rs_b;
    logic                stall;
    logic [15:0]         busy;
    logic                wb_err;
`ifdef WB_BYPASS_EN
    logic                byp_a_hit, byp_b_hit;
    logic [TAM-1:0]      byp_a_data, byp_b_data;
`endif

    typedef struct {
        logic [3:0]     a;
        logic [TAM-1:0] d;
    } wr_t;

    wr_t q[$];
    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler #(.TAM(TAM), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rs_a_en(rs_a_en), .rs_b_en(rs_b_en), .rs_a(rs_a), .rs_b(rs_b),
        .stall(stall), .busy(busy), .wb_err(wb_err)
`ifdef WB_BYPASS_EN
        , .byp_a_hit(byp_a_hit), .byp_b_hit(byp_b_hit),
        .byp_a_data(byp_a_data), .byp_b_data(byp_b_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [3:0] a, input logic [TAM-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        q.push_back(e);
    endtask

    // advance one edge, then retire any write the DUT produced against the scoreboard
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (wr_en) begin
            if (q.size() == 0) chk("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            else begin
                e = q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.a));
                chk("wr_data", 32'(wr_data), 32'(e.d));
            end
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reserve(input logic [3:0] a);
        rsv_en = 1'b1;
        rsv_addr = a;
        tick();
        rsv_en = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [TAM-1:0] d);
        req_addr[4*i +: 4] = a;
        req_data[TAM*i +: TAM] = d;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        rs_a_en = 1'b0; rs_b_en = 1'b0; rs_a = '0; rs_b = '0;
        req_valid = 3'b001;
        #3;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr_en", 32'(wr_en), 32'h0);
        chk("rst_wr_addr", 32'(wr_addr), 32'h0);
        chk("rst_wr_data", 32'(wr_data), 32'h0);
        chk("rst_wb_err", 32'(wb_err), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        req_valid = '0;
        #9 rst = 1'b1;

        // reset and basic write
        tick();
        rsv_en = 1'b1; rsv_addr = 4'd5;
        settle();
        chk("rsv5_stall", 32'(stall), 32'h0);
        tick();
        rsv_en = 1'b0;
        chk("rsv5_busy", 32'(busy), 32'h0020);
        set_req(0, 4'd5, 16'hA5A5);
        req_valid = 3'b001;
        settle();
        chk("basic_ready", 32'(req_ready), 32'h1);
        expect_wr(4'd5, 16'hA5A5);
        tick();
        req_valid = '0;
        chk("basic_wr_en", 32'(wr_en), 32'h1);
        chk("basic_busy", 32'(busy), 32'h0);
        chk("basic_wb_err", 32'(wb_err), 32'h0);
        tick();
        chk("idle_wr_en", 32'(wr_en), 32'h0);
        chk("idle_wr_addr_hold", 32'(wr_addr), 32'h5);

        // round robin from rr_ptr=0 after a fresh reset
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        reserve(4'd1);
        reserve(4'd2);
        reserve(4'd3);
        chk("rr_busy", 32'(busy), 32'h000E);
        set_req(0, 4'd1, 16'h1111);
        set_req(1, 4'd2, 16'h2222);
        set_req(2, 4'd3, 16'h3333);
        req_valid = 3'b111;
        settle();
        chk("rr_grant0", 32'(req_ready), 32'b001);
        expect_wr(4'd1, 16'h1111);
        tick();
        req_valid[0] = 1'b0;
        settle();
        chk("rr_grant1", 32'(req_ready), 32'b010);
        expect_wr(4'd2, 16'h2222);
        tick();
        req_valid[1] = 1'b0;
        settle();
        chk("rr_grant2", 32'(req_ready), 32'b100);
        expect_wr(4'd3, 16'h3333);
        tick();
        req_valid = '0;
        chk("rr_busy_clear", 32'(busy), 32'h0);
        chk("rr_wb_err", 32'(wb_err), 32'h0);

        // RAW stall on r7 (rr_ptr=0)
        reserve(4'd7);
        rs_a_en = 1'b1; rs_a = 4'd7;
        settle();
        chk("raw_stall", 32'(stall), 32'h1);
        tick();
        chk("raw_stall_hold", 32'(stall), 32'h1);
        set_req(1, 4'd7, 16'hBEEF);
        req_valid = 3'b010;
        settle();
        chk("raw_ready", 32'(req_ready), 32'b010);
`ifdef WB_BYPASS_EN
        chk("raw_stall_accept", 32'(stall), 32'h0);
        chk("byp_a_hit", 32'(byp_a_hit), 32'h1);
        chk("byp_a_data", 32'(byp_a_data), 32'hBEEF);
        chk("byp_b_hit", 32'(byp_b_hit), 32'h0);
`else
        chk("raw_stall_accept", 32'(stall), 32'h1);
`endif
        expect_wr(4'd7, 16'hBEEF);
        tick();
        req_valid = '0;
        chk("raw_stall_after", 32'(stall), 32'h0);
        rs_a_en = 1'b0;

        // WAW: reserving a busy register stalls and is ignored (rr_ptr=2)
        reserve(4'd3);
        rsv_en = 1'b1; rsv_addr = 4'd3;
        set_req(2, 4'd3, 16'h0333);
        req_valid = 3'b100;
        settle();
        chk("waw_stall", 32'(stall), 32'h1);
        expect_wr(4'd3, 16'h0333);
        tick();
        rsv_en = 1'b0;
        req_valid = '0;
        chk("waw_ignored", 32'(busy), 32'h0);

        // unreserved write to r9 (rr_ptr=0)
        set_req(0, 4'd9, 16'h0001);
        req_valid = 3'b001;
        settle();
        chk("unres_err_before", 32'(wb_err), 32'h0);
        expect_wr(4'd9, 16'h0001);
        tick();
        req_valid = '0;
        chk("unres_wr_en", 32'(wr_en), 32'h1);
        chk("unres_err", 32'(wb_err), 32'h1);
        tick();
        chk("unres_err_sticky", 32'(wb_err), 32'h1);

        // simultaneous set and clear of r4 (rr_ptr=1)
        rsv_en = 1'b1; rsv_addr = 4'd4;
        set_req(1, 4'd4, 16'h4444);
        req_valid = 3'b010;
        settle();
        chk("setclr_stall", 32'(stall), 32'h0);
        expect_wr(4'd4, 16'h4444);
        tick();
        rsv_en = 1'b0;
        req_valid = '0;
        chk("setclr_busy", 32'(busy), 32'h0010);
        chk("setclr_err_sticky", 32'(wb_err), 32'h1);

        // async reset mid-burst (rr_ptr=2)
        reserve(4'd1);
        reserve(4'd2);
        chk("burst_busy", 32'(busy), 32'h0016);
        set_req(0, 4'd1, 16'h0A01);
        set_req(1, 4'd2, 16'h0A02);
        set_req(2, 4'd3, 16'h0A03);
        req_valid = 3'b111;
        expect_wr(4'd3, 16'h0A03);
        tick();
        req_valid[2] = 1'b0;
        expect_wr(4'd1, 16'h0A01);
        tick();
        req_valid[0] = 1'b0;
        settle();
        chk("burst_ready_pre", 32'(req_ready), 32'b010);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_wr_en", 32'(wr_en), 32'h0);
        chk("arst_ready", 32'(req_ready), 32'h0);
        chk("arst_wb_err", 32'(wb_err), 32'h0);
        tick();
        chk("arst_no_write", 32'(wr_en), 32'h0);
        #2 rst = 1'b1;
        req_valid = 3'b111;
        settle();
        chk("arst_rr_ptr0", 32'(req_ready), 32'b001);
        req_valid = '0;
        tick();
        chk("end_wr_en", 32'(wr_en), 32'h0);
        chk("scoreboard_empty", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
